// File: rtl/rs_issue_responder_if.sv
// ---------------------------------------------------------------------------
// rs_issue_responder_if
// Bundles every non-clock signal of the fetch->RS issue responder:
//   issue request   : unit, reg1, reg2, reg3, hasimm, imm, enable -> out (ack)
//   register read   : regread, regin -> regout (status tag), regoutrf (value)
//   common data bus : cdb_valid, cdb_tag, cdb_value
//   dispatch link   : disp_valid/disp_ready, disp_unit, disp_tag, disp_a/b/c
//   status          : halted
// modport master : the fetch / execution side that drives requests
// modport slave  : the responder (rs_issue_responder)
// ---------------------------------------------------------------------------
interface rs_issue_responder_if #(
    parameter int WORD_W = 32,
    parameter int REG_W  = 6,
    parameter int TAG_W  = 8
) ();
    logic [2:0]        unit;
    logic [REG_W-1:0]  reg1;
    logic [REG_W-1:0]  reg2;
    logic [REG_W-1:0]  reg3;
    logic              hasimm;
    logic [WORD_W-1:0] imm;
    logic              enable;
    logic              out;

    logic              regread;
    logic [REG_W-1:0]  regin;
    logic [TAG_W-1:0]  regout;
    logic [WORD_W-1:0] regoutrf;

    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [WORD_W-1:0] cdb_value;

    logic              disp_valid;
    logic              disp_ready;
    logic [2:0]        disp_unit;
    logic [TAG_W-1:0]  disp_tag;
    logic [WORD_W-1:0] disp_a;
    logic [WORD_W-1:0] disp_b;
    logic [WORD_W-1:0] disp_c;

    logic              halted;

    modport master (
        output unit, reg1, reg2, reg3, hasimm, imm, enable,
        output regread, regin,
        output cdb_valid, cdb_tag, cdb_value,
        output disp_ready,
        input  out, regout, regoutrf,
        input  disp_valid, disp_unit, disp_tag, disp_a, disp_b, disp_c,
        input  halted
    );

    modport slave (
        input  unit, reg1, reg2, reg3, hasimm, imm, enable,
        input  regread, regin,
        input  cdb_valid, cdb_tag, cdb_value,
        input  disp_ready,
        output out, regout, regoutrf,
        output disp_valid, disp_unit, disp_tag, disp_a, disp_b, disp_c,
        output halted
    );
endinterface

// File: rtl/rs_issue_responder.sv
// ---------------------------------------------------------------------------
// rs_issue_responder
// Responder side of the fetch->RS issue handshake. Owns the register file and
// the register-status (tag) table, allocates reservation-station entries,
// wakes waiting operands from the CDB and dispatches ready entries.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : rs_issue_responder_if.slave (issue, regread, CDB, dispatch, halted)
//
// Configuration macro: CDB_BYPASS_EN
//   defined   : an allocation or register read in a CDB cycle sees the
//               broadcast value directly.
//   undefined : no allocation happens in a CDB cycle (it slips one cycle);
//               register reads show the pre-CDB state.
// ---------------------------------------------------------------------------
module rs_issue_responder #(
    parameter int DEPTH  = 8,
    parameter int WORD_W = 32,
    parameter int REG_W  = 6,
    parameter int TAG_W  = 8
) (
    input logic              clk,
    input logic              rst,
    rs_issue_responder_if.slave bus
);
    localparam int NREG  = 2 ** REG_W;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [TAG_W-1:0] TAG_READY = TAG_W'(8'h7F);
    localparam logic [TAG_W-1:0] TAG_IDLE  = TAG_W'(8'hFF);

    localparam logic [2:0] U_LW   = 3'b000;
    localparam logic [2:0] U_SW   = 3'b001;
    localparam logic [2:0] U_ADD  = 3'b010;
    localparam logic [2:0] U_MUL  = 3'b011;
    localparam logic [2:0] U_MV   = 3'b100;
    localparam logic [2:0] U_HALT = 3'b101;

    typedef enum logic {S_IDLE, S_ACK} state_t;

    state_t state, state_next;

    // Entry storage; operand A = reg2, B = reg3/imm, C = reg1 (sw data only).
    logic [DEPTH-1:0]  busy, done, a_rdy, b_rdy, c_rdy;
    logic [2:0]        e_unit [DEPTH];
    logic [WORD_W-1:0] a_val  [DEPTH];
    logic [WORD_W-1:0] b_val  [DEPTH];
    logic [WORD_W-1:0] c_val  [DEPTH];
    logic [TAG_W-1:0]  a_tag  [DEPTH];
    logic [TAG_W-1:0]  b_tag  [DEPTH];
    logic [TAG_W-1:0]  c_tag  [DEPTH];

    logic [WORD_W-1:0] rf     [NREG];
    logic [TAG_W-1:0]  status [NREG];

    logic              halt_flag;
    logic              free_found;
    logic [IDX_W-1:0]  free_idx;
    logic              alloc, take_halt, cdb_block, cdb_hit, writes_dest;
    logic [IDX_W-1:0]  cdb_idx;

    logic [REG_W-1:0]  src_reg [3];
    logic [WORD_W-1:0] src_val [3];
    logic [TAG_W-1:0]  src_tag [3];
    logic [2:0]        src_rdy;

    logic [DEPTH-1:0]  entry_ready;
    logic              any_ready, lock, disp_fire;
    logic [IDX_W-1:0]  low_idx, sel_idx, lock_idx;

    logic [TAG_W-1:0]  rd_tag;
    logic [WORD_W-1:0] rd_val;

    // Tags outside the entry range can never name a live entry.
    assign cdb_hit = bus.cdb_valid && (bus.cdb_tag < TAG_W'(DEPTH));
    assign cdb_idx = bus.cdb_tag[IDX_W-1:0];

`ifdef CDB_BYPASS_EN
    assign cdb_block = 1'b0;
`else
    assign cdb_block = bus.cdb_valid;
`endif

    assign writes_dest = (bus.unit == U_LW) || (bus.unit == U_ADD) ||
                         (bus.unit == U_MUL) || (bus.unit == U_MV);

    // Lowest free entry: scanning downward lets the lowest index win.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Operand lookup for the request being issued. Operand C only carries
    // real data for sw; everything else gets a ready zero.
    assign src_reg[0] = bus.reg2;
    assign src_reg[1] = bus.reg3;
    assign src_reg[2] = bus.reg1;

    always_comb begin
        for (int s = 0; s < 3; s++) begin
            src_tag[s] = status[src_reg[s]];
            src_val[s] = rf[src_reg[s]];
            src_rdy[s] = (status[src_reg[s]] == TAG_READY);
`ifdef CDB_BYPASS_EN
            if (!src_rdy[s] && bus.cdb_valid && (src_tag[s] == bus.cdb_tag)) begin
                src_val[s] = bus.cdb_value;
                src_rdy[s] = 1'b1;
            end
`endif
        end
        if (bus.hasimm) begin
            src_val[1] = bus.imm;
            src_tag[1] = TAG_READY;
            src_rdy[1] = 1'b1;
        end
        if (bus.unit != U_SW) begin
            src_val[2] = '0;
            src_tag[2] = TAG_READY;
            src_rdy[2] = 1'b1;
        end
    end

    // Issue FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Issue FSM next state. Halt needs no entry, so it is acknowledged even
    // when the RS is full.
    always_comb begin
        state_next = state;
        alloc      = 1'b0;
        take_halt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.enable && !cdb_block) begin
                    if (bus.unit == U_HALT) begin
                        take_halt  = 1'b1;
                        state_next = S_ACK;
                    end else if (free_found) begin
                        alloc      = 1'b1;
                        state_next = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (!bus.enable) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign bus.out    = (state == S_ACK);
    assign bus.halted = halt_flag && (busy == '0);

    // Entry table: CDB wake-up and free, dispatch marking, then allocation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy  <= '0;
            done  <= '0;
            a_rdy <= '0;
            b_rdy <= '0;
            c_rdy <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                e_unit[i] <= '0;
                a_val[i]  <= '0;
                b_val[i]  <= '0;
                c_val[i]  <= '0;
                a_tag[i]  <= TAG_IDLE;
                b_tag[i]  <= TAG_IDLE;
                c_tag[i]  <= TAG_IDLE;
            end
        end else begin
            if (cdb_hit) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (busy[i] && !a_rdy[i] && (a_tag[i] == bus.cdb_tag)) begin
                        a_val[i] <= bus.cdb_value;
                        a_rdy[i] <= 1'b1;
                    end
                    if (busy[i] && !b_rdy[i] && (b_tag[i] == bus.cdb_tag)) begin
                        b_val[i] <= bus.cdb_value;
                        b_rdy[i] <= 1'b1;
                    end
                    if (busy[i] && !c_rdy[i] && (c_tag[i] == bus.cdb_tag)) begin
                        c_val[i] <= bus.cdb_value;
                        c_rdy[i] <= 1'b1;
                    end
                end
                busy[cdb_idx] <= 1'b0;
            end
            if (disp_fire) done[sel_idx] <= 1'b1;
            if (alloc) begin
                busy[free_idx]   <= 1'b1;
                done[free_idx]   <= 1'b0;
                e_unit[free_idx] <= bus.unit;
                a_val[free_idx]  <= src_val[0];
                a_tag[free_idx]  <= src_tag[0];
                a_rdy[free_idx]  <= src_rdy[0];
                b_val[free_idx]  <= src_val[1];
                b_tag[free_idx]  <= src_tag[1];
                b_rdy[free_idx]  <= src_rdy[1];
                c_val[free_idx]  <= src_val[2];
                c_tag[free_idx]  <= src_tag[2];
                c_rdy[free_idx]  <= src_rdy[2];
            end
        end
    end

    // Register file and status table. The allocation update comes last so a
    // new producer tag overrides a same-cycle CDB retire of that register,
    // while the CDB value is still written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                rf[r]     <= '0;
                status[r] <= TAG_READY;
            end
        end else begin
            if (cdb_hit) begin
                for (int r = 0; r < NREG; r++) begin
                    if (status[r] == bus.cdb_tag) begin
                        rf[r]     <= bus.cdb_value;
                        status[r] <= TAG_READY;
                    end
                end
            end
            if (alloc && writes_dest) status[bus.reg1] <= TAG_W'(free_idx);
        end
    end

    // Sticky halt flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            halt_flag <= 1'b0;
        else if (take_halt) halt_flag <= 1'b1;
    end

    // Dispatch selection: lowest ready entry, unless an offer is already
    // pending, in which case that entry is held until accepted.
    always_comb begin
        any_ready = 1'b0;
        low_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            entry_ready[i] = busy[i] && !done[i] && a_rdy[i] && b_rdy[i] && c_rdy[i];
            if (entry_ready[i]) begin
                any_ready = 1'b1;
                low_idx   = IDX_W'(i);
            end
        end
        sel_idx = (lock && entry_ready[lock_idx]) ? lock_idx : low_idx;
    end

    assign disp_fire      = any_ready && bus.disp_ready;
    assign bus.disp_valid = any_ready;
    assign bus.disp_unit  = any_ready ? e_unit[sel_idx] : 3'b000;
    assign bus.disp_tag   = any_ready ? TAG_W'(sel_idx) : '0;
    assign bus.disp_a     = any_ready ? a_val[sel_idx] : '0;
    assign bus.disp_b     = any_ready ? b_val[sel_idx] : '0;
    assign bus.disp_c     = any_ready ? c_val[sel_idx] : '0;

    // Remember a refused offer so a lower entry waking up cannot replace it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock     <= 1'b0;
            lock_idx <= '0;
        end else begin
            lock     <= any_ready && !bus.disp_ready;
            lock_idx <= sel_idx;
        end
    end

    // Register read view, optionally showing a same-cycle CDB retire.
    always_comb begin
        rd_tag = status[bus.regin];
        rd_val = rf[bus.regin];
`ifdef CDB_BYPASS_EN
        if (bus.cdb_valid && (rd_tag != TAG_READY) && (rd_tag == bus.cdb_tag)) begin
            rd_tag = TAG_READY;
            rd_val = bus.cdb_value;
        end
`endif
    end

    // Registered read port; an idle port reports the IDLE tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.regout   <= TAG_IDLE;
            bus.regoutrf <= '0;
        end else if (bus.regread) begin
            bus.regout   <= rd_tag;
            bus.regoutrf <= rd_val;
        end else begin
            bus.regout   <= TAG_IDLE;
        end
    end
endmodule

// File: tb/tb_rs_issue_responder.sv
// ---------------------------------------------------------------------------
// tb_rs_issue_responder
// Directed bench for rs_issue_responder: reset mid-handshake, immediate
// issue/dispatch, CDB wake-up, RS-full back-pressure, CDB/issue collision
// (both CDB_BYPASS_EN builds), sw operand C and halt drain.
// ---------------------------------------------------------------------------
module tb_rs_issue_responder;
    localparam logic [2:0] U_SW   = 3'b001;
    localparam logic [2:0] U_ADD  = 3'b010;
    localparam logic [2:0] U_MV   = 3'b100;
    localparam logic [2:0] U_HALT = 3'b101;

    logic clk;
    logic rst;
    int   assertCount;
    int   failCount;
    int   lat;
    logic [7:0]  rt;
    logic [31:0] rv;

    rs_issue_responder_if #(.WORD_W(32), .REG_W(6), .TAG_W(8)) bus ();

    rs_issue_responder #(.DEPTH(8), .WORD_W(32), .REG_W(6), .TAG_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a handshake wait is ever broken.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Full 4-phase issue; lat reports cycles from enable to acknowledge.
    task automatic applyStimulus(input logic [2:0] u, input logic [5:0] r1,
                                 input logic [5:0] r2, input logic [5:0] r3,
                                 input logic hi, input logic [31:0] iv,
                                 output int latency);
        int n;
        bus.unit   = u;
        bus.reg1   = r1;
        bus.reg2   = r2;
        bus.reg3   = r3;
        bus.hasimm = hi;
        bus.imm    = iv;
        bus.enable = 1'b1;
        latency = 0;
        while (!bus.out && latency < 20) begin
            step();
            latency++;
        end
        checkOutput("issue_ack", {63'd0, bus.out}, 64'd1);
        bus.enable = 1'b0;
        n = 0;
        while (bus.out && n < 20) begin
            step();
            n++;
        end
        checkOutput("issue_drop", {63'd0, bus.out}, 64'd0);
    endtask

    task automatic cdbPulse(input logic [7:0] tag, input logic [31:0] value);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = tag;
        bus.cdb_value = value;
        step();
        bus.cdb_valid = 1'b0;
    endtask

    task automatic regRead(input logic [5:0] r, output logic [7:0] t,
                           output logic [31:0] v);
        bus.regread = 1'b1;
        bus.regin   = r;
        step();
        t = bus.regout;
        v = bus.regoutrf;
        bus.regread = 1'b0;
    endtask

    task automatic freeAll();
        for (int t = 0; t < 8; t++) cdbPulse(8'(t), 32'd0);
    endtask

    initial begin
        assertCount   = 0;
        failCount     = 0;
        rst           = 1'b0;
        bus.unit      = 3'b000;
        bus.reg1      = '0;
        bus.reg2      = '0;
        bus.reg3      = '0;
        bus.hasimm    = 1'b0;
        bus.imm       = '0;
        bus.enable    = 1'b0;
        bus.regread   = 1'b0;
        bus.regin     = '0;
        bus.cdb_valid = 1'b0;
        bus.cdb_tag   = '0;
        bus.cdb_value = '0;
        bus.disp_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_out",        {63'd0, bus.out}, 64'd0);
        checkOutput("rst_regout",     {56'd0, bus.regout}, 64'hFF);
        checkOutput("rst_regoutrf",   {32'd0, bus.regoutrf}, 64'd0);
        checkOutput("rst_disp_valid", {63'd0, bus.disp_valid}, 64'd0);
        checkOutput("rst_disp_tag",   {56'd0, bus.disp_tag}, 64'd0);
        checkOutput("rst_halted",     {63'd0, bus.halted}, 64'd0);
        step();
        rst = 1'b0;
        step();

        // Reset while acknowledging.
        $display("[TB] reset mid-ACK");
        bus.unit = U_MV; bus.reg1 = 6'd1; bus.reg2 = 6'd0; bus.hasimm = 1'b1;
        bus.imm = 32'd9; bus.enable = 1'b1;
        step();
        checkOutput("t1_out_before", {63'd0, bus.out}, 64'd1);
        rst = 1'b1;
        #1;
        checkOutput("t1_out",        {63'd0, bus.out}, 64'd0);
        checkOutput("t1_regout",     {56'd0, bus.regout}, 64'hFF);
        checkOutput("t1_halted",     {63'd0, bus.halted}, 64'd0);
        checkOutput("t1_disp_valid", {63'd0, bus.disp_valid}, 64'd0);
        bus.enable = 1'b0;
        step();
        rst = 1'b0;
        step();
        regRead(6'd1, rt, rv);
        checkOutput("t1_r1_status", {56'd0, rt}, 64'h7F);
        checkOutput("t1_r1_value",  {32'd0, rv}, 64'd0);

        // mv r1,#5: ready at once.
        $display("[TB] mv immediate");
        bus.disp_ready = 1'b0;
        applyStimulus(U_MV, 6'd1, 6'd0, 6'd0, 1'b1, 32'd5, lat);
        checkOutput("t2_ack_latency", 64'(lat), 64'd1);
        checkOutput("t2_disp_valid", {63'd0, bus.disp_valid}, 64'd1);
        checkOutput("t2_disp_unit",  {61'd0, bus.disp_unit}, 64'd4);
        checkOutput("t2_disp_b",     {32'd0, bus.disp_b}, 64'd5);
        checkOutput("t2_disp_tag",   {56'd0, bus.disp_tag}, 64'd0);
        regRead(6'd1, rt, rv);
        checkOutput("t2_r1_pending", {56'd0, rt}, 64'h00);
        bus.disp_ready = 1'b1;
        step();
        checkOutput("t2_dispatched", {63'd0, bus.disp_valid}, 64'd0);
        cdbPulse(8'd0, 32'd5);
        regRead(6'd1, rt, rv);
        checkOutput("t2_r1_status", {56'd0, rt}, 64'h7F);
        checkOutput("t2_r1_value",  {32'd0, rv}, 64'd5);

        // add r2,r1,r3 waiting on tag0.
        $display("[TB] add waits on CDB");
        applyStimulus(U_MV, 6'd1, 6'd0, 6'd0, 1'b1, 32'd7, lat);
        applyStimulus(U_ADD, 6'd2, 6'd1, 6'd3, 1'b0, 32'd0, lat);
        checkOutput("t3_no_dispatch", {63'd0, bus.disp_valid}, 64'd0);
        cdbPulse(8'd0, 32'd7);
        checkOutput("t3_disp_valid", {63'd0, bus.disp_valid}, 64'd1);
        checkOutput("t3_disp_a",     {32'd0, bus.disp_a}, 64'd7);
        checkOutput("t3_disp_b",     {32'd0, bus.disp_b}, 64'd0);
        checkOutput("t3_disp_tag",   {56'd0, bus.disp_tag}, 64'd1);
        checkOutput("t3_disp_unit",  {61'd0, bus.disp_unit}, 64'd2);
        step();
        cdbPulse(8'd1, 32'd12);
        regRead(6'd2, rt, rv);
        checkOutput("t3_r2_status", {56'd0, rt}, 64'h7F);
        checkOutput("t3_r2_value",  {32'd0, rv}, 64'd12);

        // sw r2 -> operand C carries store data, no status written.
        bus.disp_ready = 1'b0;
        applyStimulus(U_SW, 6'd2, 6'd0, 6'd0, 1'b1, 32'd4, lat);
        checkOutput("sw_disp_unit", {61'd0, bus.disp_unit}, 64'd1);
        checkOutput("sw_disp_c",    {32'd0, bus.disp_c}, 64'd12);
        checkOutput("sw_disp_b",    {32'd0, bus.disp_b}, 64'd4);
        regRead(6'd2, rt, rv);
        checkOutput("sw_r2_status", {56'd0, rt}, 64'h7F);
        bus.disp_ready = 1'b1;
        step();
        cdbPulse(8'd0, 32'd0);

        // Fill all 8 entries, then back-pressure.
        $display("[TB] RS full back-pressure");
        for (int i = 0; i < 8; i++)
            applyStimulus(U_MV, 6'(10 + i), 6'd0, 6'd0, 1'b1, 32'(100 + i), lat);
        bus.unit = U_MV; bus.reg1 = 6'd9; bus.reg2 = 6'd0; bus.hasimm = 1'b1;
        bus.imm = 32'd55; bus.enable = 1'b1;
        repeat (5) step();
        checkOutput("t4_backpressure", {63'd0, bus.out}, 64'd0);
        cdbPulse(8'd3, 32'd103);
        checkOutput("t4_out_cdb_cycle", {63'd0, bus.out}, 64'd0);
        step();
        checkOutput("t4_out_after_free", {63'd0, bus.out}, 64'd1);
        checkOutput("t4_disp_valid",     {63'd0, bus.disp_valid}, 64'd1);
        checkOutput("t4_disp_tag",       {56'd0, bus.disp_tag}, 64'd3);
        checkOutput("t4_disp_b",         {32'd0, bus.disp_b}, 64'd55);
        bus.enable = 1'b0;
        step();
        checkOutput("t4_out_drop", {63'd0, bus.out}, 64'd0);
        freeAll();
        regRead(6'd13, rt, rv);
        checkOutput("t4_r13_status", {56'd0, rt}, 64'h7F);
        checkOutput("t4_r13_value",  {32'd0, rv}, 64'd103);

        // CDB tag3 in the same cycle as an issue sourcing it.
        $display("[TB] CDB/issue collision");
        for (int i = 0; i < 4; i++)
            applyStimulus(U_MV, 6'(20 + i), 6'd0, 6'd0, 1'b1, 32'(i), lat);
        repeat (3) step();
        bus.disp_ready = 1'b0;
        bus.unit = U_ADD; bus.reg1 = 6'd24; bus.reg2 = 6'd23; bus.reg3 = 6'd0;
        bus.hasimm = 1'b0; bus.enable = 1'b1;
        bus.regread = 1'b1; bus.regin = 6'd23;
        cdbPulse(8'd3, 32'd99);
        bus.regread = 1'b0;
`ifdef CDB_BYPASS_EN
        checkOutput("t5_regout_bypass", {56'd0, bus.regout}, 64'h7F);
        checkOutput("t5_regoutrf",      {32'd0, bus.regoutrf}, 64'd99);
        checkOutput("t5_out_now",       {63'd0, bus.out}, 64'd1);
`else
        checkOutput("t5_regout_pre",    {56'd0, bus.regout}, 64'h03);
        checkOutput("t5_out_slip",      {63'd0, bus.out}, 64'd0);
        step();
        checkOutput("t5_out_late",      {63'd0, bus.out}, 64'd1);
`endif
        checkOutput("t5_disp_valid", {63'd0, bus.disp_valid}, 64'd1);
        checkOutput("t5_disp_unit",  {61'd0, bus.disp_unit}, 64'd2);
        checkOutput("t5_disp_a",     {32'd0, bus.disp_a}, 64'd99);
`ifdef CDB_BYPASS_EN
        checkOutput("t5_disp_tag",   {56'd0, bus.disp_tag}, 64'd4);
`else
        checkOutput("t5_disp_tag",   {56'd0, bus.disp_tag}, 64'd3);
`endif
        bus.enable = 1'b0;
        step();
        checkOutput("t5_out_drop", {63'd0, bus.out}, 64'd0);
        bus.disp_ready = 1'b1;
        step();
        freeAll();

        // Halt with two live entries.
        $display("[TB] halt drain");
        applyStimulus(U_MV, 6'd30, 6'd0, 6'd0, 1'b1, 32'd1, lat);
        applyStimulus(U_MV, 6'd31, 6'd0, 6'd0, 1'b1, 32'd2, lat);
        applyStimulus(U_HALT, 6'd0, 6'd0, 6'd0, 1'b0, 32'd0, lat);
        checkOutput("t6_halt_latency", 64'(lat), 64'd1);
        checkOutput("t6_halted_live",  {63'd0, bus.halted}, 64'd0);
        cdbPulse(8'd0, 32'd1);
        checkOutput("t6_halted_one",   {63'd0, bus.halted}, 64'd0);
        cdbPulse(8'd1, 32'd2);
        checkOutput("t6_halted_drain", {63'd0, bus.halted}, 64'd1);
        regRead(6'd31, rt, rv);
        checkOutput("t6_r31_value", {32'd0, rv}, 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end
endmodule
